// File: rtl/dma_timing_control.sv
// Timing-and-control engine of an 8237-style DMA controller: request arbitration,
// HRQ/HLDA handshake and the single-mode SI/SO/S1..S4 transfer sequence.
module dma_timing_control (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] DREQ,
  input  logic       HLDA,
  input  logic       EOP_N_in,
  input  logic [3:0] maskReg,
  input  logic       controllerDisable,
  input  logic       compressedTiming,
  input  logic       rotatingPriority,
  input  logic [7:0] transferType,
  input  logic [3:0] autoInit,
  input  logic       tcIn,
  output logic       HRQ,
  output logic       AEN,
  output logic       ADSTB,
  output logic [3:0] DACK,
  output logic       IOR_N,
  output logic       IOW_N,
  output logic       MEMR_N,
  output logic       MEMW_N,
  output logic       EOP_N,
  output logic [1:0] activeChannel,
  output logic       updateCounters,
  output logic       reloadChannel,
  output logic [3:0] setTC,
  output logic [3:0] setMask
);

  typedef enum logic [5:0] {
    SI = 6'b000001,
    SO = 6'b000010,
    S1 = 6'b000100,
    S2 = 6'b001000,
    S3 = 6'b010000,
    S4 = 6'b100000
  } state_t;

  state_t     state, nextState;
  logic [3:0] req_valid;
  logic       any_req;
  logic [1:0] prio_ptr;
  logic [1:0] winner;
  logic [1:0] base;
  logic [1:0] idx;
  logic [1:0] chan_q;
  logic [1:0] type_q;
  logic       comp_q;
  logic       is_rd;
  logic       is_wr;
  logic       rd_on;
  logic       wr_on;
  logic       tc_hit;

  assign req_valid = DREQ & ~maskReg & {4{~controllerDisable}};
  assign any_req   = |req_valid;
  assign tc_hit    = tcIn | ~EOP_N_in;

  // Scan from lowest to highest priority so the highest-priority valid channel wins.
  always_comb begin
    base   = rotatingPriority ? prio_ptr : 2'd0;
    winner = base;
    idx    = base;
    for (int i = 3; i >= 0; i--) begin
      idx = base + 2'(i);
      if (req_valid[idx]) winner = idx;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= SI;
      prio_ptr <= 2'd0;
      chan_q   <= 2'd0;
    end else begin
      state <= nextState;
      if (state == SO && nextState == S1) chan_q <= winner;
      if (state == S4) prio_ptr <= chan_q + 2'd1;
    end
  end

  // Transfer attributes are frozen at grant so command changes mid-transfer are harmless.
  always_ff @(posedge CLK) begin
    if (state == SO && nextState == S1) begin
      type_q <= transferType[{winner, 1'b0} +: 2];
      comp_q <= compressedTiming;
    end
  end

  always_comb begin
    nextState = SI;
    unique case (state)
      SI: nextState = any_req ? SO : SI;
      SO: begin
        if (!any_req)  nextState = SI;
        else if (HLDA) nextState = S1;
        else           nextState = SO;
      end
      S1: nextState = S2;
      S2: nextState = comp_q ? S4 : S3;
      S3: nextState = S4;
      S4: nextState = SI;
      default: nextState = SI;
    endcase
  end

  assign is_rd = (type_q == 2'b10);
  assign is_wr = (type_q == 2'b01);
  assign rd_on = (state == S2) || (state == S3) || (state == S4);
  assign wr_on = (state == S3) || (state == S4) || ((state == S2) && comp_q);

  always_comb begin
    HRQ            = 1'b0;
    AEN            = 1'b0;
    ADSTB          = 1'b0;
    DACK           = 4'b0000;
    EOP_N          = 1'b1;
    updateCounters = 1'b0;
    reloadChannel  = 1'b0;
    setTC          = 4'b0000;
    setMask        = 4'b0000;
    case (state)
      SO: HRQ = 1'b1;
      S1, S2, S3, S4: begin
        HRQ   = 1'b1;
        AEN   = 1'b1;
        ADSTB = (state == S1);
        DACK  = 4'b0001 << chan_q;
      end
      default: ;
    endcase
    if (state == S4) begin
      updateCounters = 1'b1;
      if (tc_hit) begin
        EOP_N = 1'b0;
        setTC = 4'b0001 << chan_q;
        if (autoInit[chan_q]) reloadChannel = 1'b1;
        else                  setMask       = 4'b0001 << chan_q;
      end
    end
  end

  assign MEMR_N        = ~(rd_on & is_rd);
  assign IOR_N         = ~(rd_on & is_wr);
  assign IOW_N         = ~(wr_on & is_rd);
  assign MEMW_N        = ~(wr_on & is_wr);
  assign activeChannel = chan_q;

endmodule

// File: tb/tb_dma_timing_control.sv
// Randomized and directed bench for dma_timing_control against a cycle-table reference model.
module tb_dma_timing_control;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] DREQ;
  logic       HLDA;
  logic       EOP_N_in;
  logic [3:0] maskReg;
  logic       controllerDisable;
  logic       compressedTiming;
  logic       rotatingPriority;
  logic [7:0] transferType;
  logic [3:0] autoInit;
  logic       tcIn;
  logic       HRQ, AEN, ADSTB;
  logic [3:0] DACK;
  logic       IOR_N, IOW_N, MEMR_N, MEMW_N, EOP_N;
  logic [1:0] activeChannel;
  logic       updateCounters, reloadChannel;
  logic [3:0] setTC, setMask;

  dma_timing_control dut (
    .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .HLDA(HLDA), .EOP_N_in(EOP_N_in),
    .maskReg(maskReg), .controllerDisable(controllerDisable),
    .compressedTiming(compressedTiming), .rotatingPriority(rotatingPriority),
    .transferType(transferType), .autoInit(autoInit), .tcIn(tcIn),
    .HRQ(HRQ), .AEN(AEN), .ADSTB(ADSTB), .DACK(DACK),
    .IOR_N(IOR_N), .IOW_N(IOW_N), .MEMR_N(MEMR_N), .MEMW_N(MEMW_N), .EOP_N(EOP_N),
    .activeChannel(activeChannel), .updateCounters(updateCounters),
    .reloadChannel(reloadChannel), .setTC(setTC), .setMask(setMask)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  logic [29:0] act_q[$];
  logic [29:0] exp_q[$];
  logic [1:0]  model_ch;
  logic [1:0]  model_start;

  localparam int P_SI = 0, P_SO = 1, P_S1 = 2, P_S2 = 3, P_S3 = 4, P_S4 = 5;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [29:0] sample();
    return {dut.state, HRQ, AEN, ADSTB, DACK, IOR_N, IOW_N, MEMR_N, MEMW_N, EOP_N,
            activeChannel, updateCounters, reloadChannel, setTC, setMask};
  endfunction

  // Expected bus picture for a given phase, straight from the phase description table.
  function automatic logic [29:0] expv(input int ph, input logic [1:0] ch, input logic [1:0] ty,
                                       input logic comp, input logic hit, input logic ai);
    logic [5:0] st;
    logic hrq, aen, adstb, rd_on, wr_on, s4;
    logic [3:0] dack, stc, smk;
    st    = 6'b000001 << ph;
    hrq   = (ph >= P_SO);
    aen   = (ph >= P_S1);
    adstb = (ph == P_S1);
    dack  = (ph >= P_S1) ? (4'b0001 << ch) : 4'b0000;
    rd_on = (ph >= P_S2);
    wr_on = (ph >= P_S3) || (ph == P_S2 && comp);
    s4    = (ph == P_S4);
    stc   = (s4 && hit) ? (4'b0001 << ch) : 4'b0000;
    smk   = (s4 && hit && !ai) ? (4'b0001 << ch) : 4'b0000;
    return {st, hrq, aen, adstb, dack,
            !(rd_on && ty == 2'b01), !(wr_on && ty == 2'b10),
            !(rd_on && ty == 2'b10), !(wr_on && ty == 2'b01),
            !(s4 && hit), ch, s4, (s4 && hit && ai), stc, smk};
  endfunction

  task automatic record(input logic [29:0] e);
    #1;
    act_q.push_back(sample());
    exp_q.push_back(e);
  endtask

  // Drives one complete single-mode transfer and records observed/expected per cycle.
  task automatic do_transfer(input logic [3:0] dreq, input logic [3:0] msk, input logic rot,
                             input logic comp, input logic [7:0] types, input logic [3:0] ai,
                             input logic tc, input logic eop_in, input int hlda_wait,
                             input bit in_so, input bit hold_req);
    logic [3:0] v;
    logic [1:0] w, base, c;
    logic [1:0] ty;
    logic found, hit;
    int seq[$];
    DREQ = dreq; maskReg = msk; controllerDisable = 1'b0; rotatingPriority = rot;
    compressedTiming = comp; transferType = types; autoInit = ai;
    HLDA = 1'b0; tcIn = 1'($urandom); EOP_N_in = 1'($urandom);
    if (!in_so) begin
      record(expv(P_SI, model_ch, 2'b00, 1'b0, 1'b0, 1'b0));
      tick();
    end
    for (int k = 0; k < hlda_wait; k++) begin
      tcIn = 1'($urandom); EOP_N_in = 1'($urandom);
      record(expv(P_SO, model_ch, 2'b00, 1'b0, 1'b0, 1'b0));
      tick();
    end
    HLDA = 1'b1;
    record(expv(P_SO, model_ch, 2'b00, 1'b0, 1'b0, 1'b0));
    v = dreq & ~msk;
    base = rot ? model_start : 2'd0;
    w = 2'd0; found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      c = base + 2'(i);
      if (!found && v[c]) begin w = c; found = 1'b1; end
    end
    tick();
    ty  = types[2*w +: 2];
    hit = tc | ~eop_in;
    if (comp) seq = '{P_S1, P_S2, P_S4};
    else      seq = '{P_S1, P_S2, P_S3, P_S4};
    foreach (seq[i]) begin
      HLDA = 1'($urandom);
      if (!hold_req) DREQ = 4'($urandom);
      maskReg = 4'($urandom);
      if (seq[i] == P_S4) begin tcIn = tc; EOP_N_in = eop_in; end
      else begin tcIn = 1'($urandom); EOP_N_in = 1'($urandom); end
      record(expv(seq[i], w, ty, comp, hit, ai[w]));
      tick();
    end
    model_ch = w;
    model_start = w + 2'd1;
    DREQ = hold_req ? dreq : 4'b0000; maskReg = msk;
    HLDA = 1'b0; tcIn = 1'b0; EOP_N_in = 1'b1;
    record(expv(P_SI, model_ch, 2'b00, 1'b0, 1'b0, 1'b0));
    tick();
  endtask

  task automatic test_reset();
    act_q.delete(); exp_q.delete();
    RESET = 1'b1; DREQ = 4'b1111; HLDA = 1'b1;
    tick(); tick();
    record(expv(P_SI, 2'd0, 2'b00, 1'b0, 1'b0, 1'b0));
    tick();
    record(expv(P_SI, 2'd0, 2'b00, 1'b0, 1'b0, 1'b0));
    RESET = 1'b0; DREQ = 4'b0000; HLDA = 1'b0;
    tick();
    record(expv(P_SI, 2'd0, 2'b00, 1'b0, 1'b0, 1'b0));
    tick();
    model_ch = 2'd0; model_start = 2'd0;
    foreach (act_q[i]) begin
      n_vec++;
      if (act_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL reset cyc%0d got %h exp %h", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_normal_write();
    act_q.delete(); exp_q.delete();
    do_transfer(4'b0100, 4'b0000, 1'b0, 1'b0, 8'b00_01_00_00, 4'b0000, 1'b0, 1'b1, 0, 0, 0);
    foreach (act_q[i]) begin
      n_vec++;
      if (act_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL normal_write cyc%0d got %h exp %h", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_compressed_read();
    act_q.delete(); exp_q.delete();
    do_transfer(4'b1000, 4'b0000, 1'b0, 1'b1, 8'b10_00_00_00, 4'b0000, 1'b0, 1'b1, 1, 0, 0);
    foreach (act_q[i]) begin
      n_vec++;
      if (act_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL compressed_read cyc%0d got %h exp %h", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_terminal_count();
    act_q.delete(); exp_q.delete();
    do_transfer(4'b0001, 4'b0000, 1'b0, 1'b0, 8'b00_00_00_01, 4'b0000, 1'b1, 1'b1, 0, 0, 0);
    do_transfer(4'b0001, 4'b0000, 1'b0, 1'b0, 8'b00_00_00_10, 4'b0001, 1'b1, 1'b1, 0, 0, 0);
    do_transfer(4'b0001, 4'b0000, 1'b0, 1'b1, 8'b00_00_00_00, 4'b0000, 1'b0, 1'b0, 0, 0, 0);
    foreach (act_q[i]) begin
      n_vec++;
      if (act_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL terminal_count cyc%0d got %h exp %h", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_handshake();
    act_q.delete(); exp_q.delete();
    DREQ = 4'b0001; maskReg = 4'b0000; controllerDisable = 1'b0; HLDA = 1'b0;
    record(expv(P_SI, model_ch, 2'b00, 1'b0, 1'b0, 1'b0));
    tick();
    repeat (4) begin
      record(expv(P_SO, model_ch, 2'b00, 1'b0, 1'b0, 1'b0));
      tick();
    end
    DREQ = 4'b0000;
    record(expv(P_SO, model_ch, 2'b00, 1'b0, 1'b0, 1'b0));
    tick();
    record(expv(P_SI, model_ch, 2'b00, 1'b0, 1'b0, 1'b0));
    tick();
    DREQ = 4'b0010; maskReg = 4'b0010; HLDA = 1'b1;
    repeat (3) begin
      record(expv(P_SI, model_ch, 2'b00, 1'b0, 1'b0, 1'b0));
      tick();
    end
    maskReg = 4'b0000; controllerDisable = 1'b1;
    repeat (3) begin
      record(expv(P_SI, model_ch, 2'b00, 1'b0, 1'b0, 1'b0));
      tick();
    end
    DREQ = 4'b0000; controllerDisable = 1'b0; HLDA = 1'b0;
    tick();
    foreach (act_q[i]) begin
      n_vec++;
      if (act_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL handshake cyc%0d got %h exp %h", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    act_q.delete(); exp_q.delete();
    DREQ = 4'b0100; maskReg = 4'b0000; controllerDisable = 1'b0; HLDA = 1'b1;
    compressedTiming = 1'b0; transferType = 8'b00_01_00_00; tcIn = 1'b0; EOP_N_in = 1'b1;
    tick(); tick(); tick(); tick();
    record(expv(P_S3, 2'd2, 2'b01, 1'b0, 1'b0, 1'b0));
    RESET = 1'b1; DREQ = 4'b0000; HLDA = 1'b0;
    tick();
    RESET = 1'b0;
    model_ch = 2'd0; model_start = 2'd0;
    record(expv(P_SI, 2'd0, 2'b00, 1'b0, 1'b0, 1'b0));
    tick();
    foreach (act_q[i]) begin
      n_vec++;
      if (act_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL reset_mid cyc%0d got %h exp %h", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_priority();
    act_q.delete(); exp_q.delete();
    do_transfer(4'b1010, 4'b0000, 1'b0, 1'b0, 8'b01_01_01_01, 4'b0000, 1'b0, 1'b1, 0, 0, 0);
    do_transfer(4'b1010, 4'b0000, 1'b1, 1'b0, 8'b01_01_01_01, 4'b0000, 1'b0, 1'b1, 0, 0, 0);
    n_vec++;
    if (activeChannel !== 2'd3) begin
      n_err++;
      $display("FAIL priority_rotate got ch%0d exp ch3", activeChannel);
    end
    foreach (act_q[i]) begin
      n_vec++;
      if (act_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL priority cyc%0d got %h exp %h", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    act_q.delete(); exp_q.delete();
    do_transfer(4'b0100, 4'b0000, 1'b0, 1'b0, 8'b00_10_00_00, 4'b0000, 1'b0, 1'b1, 0, 0, 1);
    do_transfer(4'b0100, 4'b0000, 1'b0, 1'b1, 8'b00_01_00_00, 4'b0000, 1'b1, 1'b1, 0, 1, 0);
    foreach (act_q[i]) begin
      n_vec++;
      if (act_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL back_to_back cyc%0d got %h exp %h", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] dreq, msk;
    act_q.delete(); exp_q.delete();
    for (int n = 0; n < 40; n++) begin
      do begin
        dreq = 4'($urandom);
        msk  = 4'($urandom);
      end while ((dreq & ~msk) == 4'b0000);
      do_transfer(dreq, msk, 1'($urandom), 1'($urandom), 8'($urandom), 4'($urandom),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, 3)), 0, 0);
    end
    foreach (act_q[i]) begin
      n_vec++;
      if (act_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL random cyc%0d got %h exp %h", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    RESET = 1'b1; DREQ = 4'b0000; HLDA = 1'b0; EOP_N_in = 1'b1; maskReg = 4'b0000;
    controllerDisable = 1'b0; compressedTiming = 1'b0; rotatingPriority = 1'b0;
    transferType = 8'h00; autoInit = 4'b0000; tcIn = 1'b0;
    model_ch = 2'd0; model_start = 2'd0;
    test_reset();
    test_normal_write();
    test_compressed_read();
    test_terminal_count();
    test_handshake();
    test_reset_mid();
    test_priority();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
